// File: rtl/seg7_pkg.sv
// Seven-segment encoding shared by the scan display and its counter.
package seg7_pkg;

    // Active-low segment codes, bit0 = a .. bit6 = g, bit7 = dp (off).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // AND mask that lights the decimal point (active low).
    localparam logic [7:0] SEG_DP_ON = 8'h7F;

    // Pattern selector values shown on the optional pattern digit.
    localparam logic [1:0] PAT_GLIDER  = 2'd0;
    localparam logic [1:0] PAT_BLINKER = 2'd1;
    localparam logic [1:0] PAT_BEACON  = 2'd2;
    localparam logic [1:0] PAT_USER    = 2'd3;

    // Anode bus width on the board.
    localparam int MAX_DIGITS = 8;

    // BCD digit to segment code; anything above 9 shows as blank.
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_counter_if.sv
// Bundle between the generation logic / board pins and the scan counter.
interface seg7_scan_counter_if #(
    parameter int N_DIGITS = 4
);
    logic                    gen_tick;
    logic                    clr;
    logic [1:0]              pattern_id;
    logic [4*N_DIGITS-1:0]   count_bcd;
    logic                    ovf;
    logic [7:0]              anode;
    logic [7:0]              cathode;

    // Driver side: the generation engine plus whatever reads the display.
    modport master (
        output gen_tick, clr, pattern_id,
        input  count_bcd, ovf, anode, cathode
    );

    // The scan counter itself.
    modport slave (
        input  gen_tick, clr, pattern_id,
        output count_bcd, ovf, anode, cathode
    );
endinterface

// File: rtl/seg7_scan_counter_bcd_counter.sv
// N-digit decimal counter with ripple carry, wrap or saturate on overflow.
module bcd_counter #(
    parameter int N_DIGITS = 4,
    parameter int WRAP     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  clr,
    output logic [4*N_DIGITS-1:0] q,
    output logic                  ovf
);

    logic [N_DIGITS-1:0][3:0] q_q, q_d, q_inc;
    logic                     ovf_q, ovf_d;
    logic                     carry;
    logic                     all_nines;

    // Decimal +1 with ripple carry; also detect the all-9s terminal value.
    always_comb begin
        q_inc     = q_q;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            all_nines = all_nines & (q_q[k] == 4'd9);
            if (carry) begin
                if (q_q[k] == 4'd9) begin
                    q_inc[k] = 4'd0;
                end else begin
                    q_inc[k] = q_q[k] + 4'd1;
                    carry    = 1'b0;
                end
            end
        end
    end

    // Next count/flag: clear wins; overflow either wraps with a pulse or holds sticky.
    always_comb begin
        q_d   = q_q;
        ovf_d = (WRAP != 0) ? 1'b0 : ovf_q;
        if (clr) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (all_nines) begin
                ovf_d = 1'b1;
                if (WRAP != 0) q_d = '0;
            end else begin
                q_d = q_inc;
            end
        end
    end

    // Count and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/seg7_scan_counter.sv
// Multiplexed seven-segment driver for the generation count and pattern ID.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16,
    parameter int WRAP        = 1,
    parameter int SHOW_PAT    = 1,
    parameter int LZ_BLANK    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_counter_if.slave bus
);

    // Number of scanned slots and divider width.
    localparam int              S         = N_DIGITS + ((SHOW_PAT != 0) ? 1 : 0);
    localparam int              DW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST  = DW'(REFRESH_DIV - 1);
    localparam logic [2:0]      SLOT_LAST = 3'(S - 1);
    localparam logic [2:0]      SLOT_PAT  = 3'(N_DIGITS);

    logic [4*N_DIGITS-1:0]    count;
    logic                     ovf;

    logic [DW-1:0]            div_q, div_d;
    logic [2:0]               slot_q, slot_d;
    logic [N_DIGITS-1:0][3:0] frame_q, frame_d;
    logic [7:0]               anode_q, anode_d;
    logic [7:0]               cathode_q, cathode_d;

    logic                     in_blank;
    logic                     is_pat;
    logic                     zero_acc;
    logic [N_DIGITS-1:0]      lz_mask;
    logic [3:0]               cur_digit;
    logic                     cur_lz;

    bcd_counter #(
        .N_DIGITS (N_DIGITS),
        .WRAP     (WRAP)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.gen_tick),
        .clr   (bus.clr),
        .q     (count),
        .ovf   (ovf)
    );

    // Refresh divider, slot pointer, and per-frame snapshot of the count.
    always_comb begin
        div_d   = div_q + DW'(1);
        slot_d  = slot_q;
        frame_d = frame_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            if (slot_q == SLOT_LAST) begin
                slot_d  = 3'd0;
                frame_d = count;
            end else begin
                slot_d = slot_q + 3'd1;
            end
        end
    end

    // Anti-ghosting window at the start of every slot.
    generate
        if (BLANK_CYC > 0) begin : g_blank
            assign in_blank = (div_q < DW'(BLANK_CYC));
        end else begin : g_noblank
            assign in_blank = 1'b0;
        end
    endgenerate

    // Leading-zero mask: digit k is suppressed when it and every digit above are zero.
    always_comb begin
        zero_acc = 1'b1;
        lz_mask  = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_acc = zero_acc & (frame_q[k] == 4'd0);
            if (k > 0 && LZ_BLANK != 0) lz_mask[k] = zero_acc;
        end
    end

    // Pick the latched digit for the current slot.
    always_comb begin
        cur_digit = 4'd0;
        cur_lz    = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (slot_q == 3'(k)) begin
                cur_digit = frame_q[k];
                cur_lz    = lz_mask[k];
            end
        end
    end

    assign is_pat = (SHOW_PAT != 0) && (slot_q == SLOT_PAT);

    // Next anode/cathode from the current divider/slot state.
    always_comb begin
        anode_d   = 8'hFF;
        cathode_d = SEG_BLANK;
        if (!in_blank) begin
            anode_d = ~(8'b1 << slot_q);
            if (is_pat) begin
                cathode_d = bcd_to_seg({2'b00, bus.pattern_id}) & SEG_DP_ON;
            end else if (!cur_lz) begin
                cathode_d = bcd_to_seg(cur_digit);
            end
        end
    end

    // Scan state and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            slot_q    <= 3'd0;
            frame_q   <= '0;
            anode_q   <= 8'hFF;
            cathode_q <= SEG_BLANK;
        end else begin
            div_q     <= div_d;
            slot_q    <= slot_d;
            frame_q   <= frame_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign bus.count_bcd = count;
    assign bus.ovf       = ovf;
    assign bus.anode     = anode_q;
    assign bus.cathode   = cathode_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Directed bench: one wrapping and one saturating instance share stimulus.
module tb_seg7_scan_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seg7_scan_counter_if #(.N_DIGITS(4)) bus_w ();
    seg7_scan_counter_if #(.N_DIGITS(4)) bus_s ();

    assign bus_s.gen_tick   = bus_w.gen_tick;
    assign bus_s.clr        = bus_w.clr;
    assign bus_s.pattern_id = bus_w.pattern_id;

    seg7_scan_counter #(
        .N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2),
        .WRAP(1), .SHOW_PAT(1), .LZ_BLANK(1)
    ) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    seg7_scan_counter #(
        .N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2),
        .WRAP(0), .SHOW_PAT(1), .LZ_BLANK(1)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks and land 1 ns after the last rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for a given anode pattern on the wrapping instance.
    task automatic wait_an(input string tag, input logic [7:0] a);
        int n;
        n = 0;
        while (bus_w.anode !== a && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, {24'd0, bus_w.anode}, {24'd0, a});
    endtask

    task automatic pulse_tick();
        bus_w.gen_tick = 1'b1;
        step(1);
        bus_w.gen_tick = 1'b0;
    endtask

    initial begin
        bus_w.gen_tick   = 1'b0;
        bus_w.clr        = 1'b0;
        bus_w.pattern_id = 2'd1;
        rst_n            = 1'b0;
        step(3);
        chk("rst_anode",   {24'd0, bus_w.anode},   32'hFF);
        chk("rst_cathode", {24'd0, bus_w.cathode}, 32'hFF);
        chk("rst_count",   {16'd0, bus_w.count_bcd}, 32'h0);
        chk("rst_ovf",     {31'd0, bus_w.ovf},     32'h0);

        // Release: two blanked cycles, then slot 0 shows a zero.
        rst_n = 1'b1;
        step(1);
        chk("rel_e1_an", {24'd0, bus_w.anode}, 32'hFF);
        step(1);
        chk("rel_e2_an", {24'd0, bus_w.anode}, 32'hFF);
        step(1);
        chk("s0_an",  {24'd0, bus_w.anode},   32'hFE);
        chk("s0_cat", {24'd0, bus_w.cathode}, 32'hC0);
        step(8);
        chk("s1_an",  {24'd0, bus_w.anode},   32'hFD);
        chk("s1_lz",  {24'd0, bus_w.cathode}, 32'hFF);
        step(8);
        chk("s2_an",  {24'd0, bus_w.anode},   32'hFB);
        chk("s2_lz",  {24'd0, bus_w.cathode}, 32'hFF);
        step(8);
        chk("s3_an",  {24'd0, bus_w.anode},   32'hF7);
        chk("s3_lz",  {24'd0, bus_w.cathode}, 32'hFF);
        step(6);
        chk("s4_blank_an",  {24'd0, bus_w.anode},   32'hFF);
        chk("s4_blank_cat", {24'd0, bus_w.cathode}, 32'hFF);
        step(2);
        chk("s4_an",  {24'd0, bus_w.anode},   32'hEF);
        chk("s4_pat", {24'd0, bus_w.cathode}, 32'h79);

        // 123 back-to-back ticks.
        bus_w.gen_tick = 1'b1;
        step(123);
        bus_w.gen_tick = 1'b0;
        chk("cnt_123", {16'd0, bus_w.count_bcd}, 32'h0123);
        wait_an("w123_s4", 8'hEF);
        wait_an("w123_s0", 8'hFE);
        chk("d123_s0", {24'd0, bus_w.cathode}, 32'hB0);
        wait_an("w123_s1", 8'hFD);
        chk("d123_s1", {24'd0, bus_w.cathode}, 32'hA4);
        wait_an("w123_s2", 8'hFB);
        chk("d123_s2", {24'd0, bus_w.cathode}, 32'hF9);
        wait_an("w123_s3", 8'hF7);
        chk("d123_s3", {24'd0, bus_w.cathode}, 32'hFF);

        // Ticks mid-frame must not disturb the frame already being shown.
        wait_an("tear_s0", 8'hFE);
        chk("tear_s0_old", {24'd0, bus_w.cathode}, 32'hB0);
        pulse_tick();
        chk("tear_cnt124", {16'd0, bus_w.count_bcd}, 32'h0124);
        chk("tear_s0_an",  {24'd0, bus_w.anode},     32'hFE);
        chk("tear_s0_hold", {24'd0, bus_w.cathode},  32'hB0);
        wait_an("tear_s2", 8'hFB);
        pulse_tick();
        chk("tear_cnt125", {16'd0, bus_w.count_bcd}, 32'h0125);
        chk("tear_s2_hold", {24'd0, bus_w.cathode},  32'hF9);
        wait_an("tear_s4", 8'hEF);
        wait_an("tear_new_s0", 8'hFE);
        chk("tear_new_val", {24'd0, bus_w.cathode},  32'h92);

        // Pattern digit follows pattern_id live.
        bus_w.pattern_id = 2'd2;
        wait_an("pat2_s4", 8'hEF);
        chk("pat2_cat", {24'd0, bus_w.cathode}, 32'h24);

        // clr wins over a simultaneous tick.
        bus_w.clr = 1'b1;
        step(1);
        bus_w.clr = 1'b0;
        chk("clr_cnt", {16'd0, bus_w.count_bcd}, 32'h0);
        bus_w.gen_tick = 1'b1;
        step(42);
        bus_w.gen_tick = 1'b0;
        chk("cnt_42", {16'd0, bus_w.count_bcd}, 32'h0042);
        bus_w.clr      = 1'b1;
        bus_w.gen_tick = 1'b1;
        step(1);
        bus_w.clr      = 1'b0;
        bus_w.gen_tick = 1'b0;
        chk("clr_tick_w", {16'd0, bus_w.count_bcd}, 32'h0);
        chk("clr_tick_s", {16'd0, bus_s.count_bcd}, 32'h0);
        chk("clr_tick_ovf", {31'd0, bus_w.ovf}, 32'h0);

        // Overflow: wrap pulses, saturate sticks.
        bus_w.gen_tick = 1'b1;
        step(9999);
        bus_w.gen_tick = 1'b0;
        chk("w_9999",   {16'd0, bus_w.count_bcd}, 32'h9999);
        chk("s_9999",   {16'd0, bus_s.count_bcd}, 32'h9999);
        chk("w_ovf_pre", {31'd0, bus_w.ovf}, 32'h0);
        chk("s_ovf_pre", {31'd0, bus_s.ovf}, 32'h0);
        pulse_tick();
        chk("w_wrap_cnt", {16'd0, bus_w.count_bcd}, 32'h0000);
        chk("w_wrap_ovf", {31'd0, bus_w.ovf}, 32'h1);
        chk("s_sat_cnt",  {16'd0, bus_s.count_bcd}, 32'h9999);
        chk("s_sat_ovf",  {31'd0, bus_s.ovf}, 32'h1);
        step(1);
        chk("w_ovf_drop", {31'd0, bus_w.ovf}, 32'h0);
        chk("s_ovf_stick", {31'd0, bus_s.ovf}, 32'h1);
        pulse_tick();
        chk("w_after_wrap", {16'd0, bus_w.count_bcd}, 32'h0001);
        chk("s_sat_hold",   {16'd0, bus_s.count_bcd}, 32'h9999);
        chk("s_ovf_hold",   {31'd0, bus_s.ovf}, 32'h1);
        bus_w.clr = 1'b1;
        step(1);
        bus_w.clr = 1'b0;
        chk("s_clr_cnt", {16'd0, bus_s.count_bcd}, 32'h0);
        chk("s_clr_ovf", {31'd0, bus_s.ovf}, 32'h0);

        // Asynchronous reset in the middle of slot 3.
        bus_w.gen_tick = 1'b1;
        step(7);
        bus_w.gen_tick = 1'b0;
        chk("cnt_7", {16'd0, bus_w.count_bcd}, 32'h0007);
        wait_an("ar_s3", 8'hF7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_anode",   {24'd0, bus_w.anode},     32'hFF);
        chk("ar_cathode", {24'd0, bus_w.cathode},   32'hFF);
        chk("ar_count",   {16'd0, bus_w.count_bcd}, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("ar_rel_e1", {24'd0, bus_w.anode}, 32'hFF);
        step(1);
        chk("ar_rel_e2", {24'd0, bus_w.anode}, 32'hFF);
        step(1);
        chk("ar_rel_an",  {24'd0, bus_w.anode},   32'hFE);
        chk("ar_rel_cat", {24'd0, bus_w.cathode}, 32'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
